ds_pixel_packer: RTL and testbench
==================================

# ds_pixel_packer

Downstream stage of the 4x downsampler. Consumes its 8-bit pixel stream (one pixel per cycle when valid, blanking-region pixels flagged), discards blanking pixels, and packs four active pixels into one 32-bit word. Words go into a small internal FIFO with a ready/valid output toward the frame-buffer writer. Each word carries start-of-frame and end-of-line tags; an overflow is recorded when the FIFO cannot absorb a word.

## Interface
Parameters:
- ACTIVE_COLS, 200: active pixels per downsampled row.
- ACTIVE_ROWS, 150: active rows per downsampled frame.
- FIFO_DEPTH, 4: word FIFO entries; power of two, at least 2.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- valid  in  1  upstream pixel strobe.
- data  in  8  upstream pixel.
- blankingregion  in  1  pixel lies in padding. Drop it even when valid=1.
- word_valid  out  1  FIFO head is valid.
- word_data  out  32  four packed pixels. The earliest pixel is in [7:0], the latest in [31:24].
- word_sof  out  1  head word is the first word of a frame.
- word_eol  out  1  head word is the last word of a row.
- word_ready  in  1  downstream accepts the head when word_valid and word_ready are both high.
- overflow  out  1  sticky: at least one word was dropped.
- overflow_clear  in  1  synchronous clear of overflow.

## Operation
- An active pixel is accepted when valid=1 and blankingregion=0. All other cycles are ignored and change no state.
- Counters:
  - col counts 0..ACTIVE_COLS-1.
  - row counts 0..ACTIVE_ROWS-1.
  - Both advance only on an accepted pixel.
  - col wraps to 0 after ACTIVE_COLS-1 and row then increments.
  - row wraps to 0 after ACTIVE_ROWS-1, starting a new frame. No other resync exists besides reset.
- Packing:
  - lane = col[1:0]. Lanes 0..2 are stored in a 24-bit holding register.
  - On lane 3, the word is {data, hold[23:16], hold[15:8], hold[7:0]} and is pushed to the FIFO in the same cycle.
  - Tags: sof = (row==0 && col==3). eol = (col==ACTIVE_COLS-1).
- ACTIVE_COLS must be a multiple of 4, so a word never spans rows.
- FIFO entries are 34 bits: data, sof, eol. It is first-word-fall-through, so word_* present the head whenever word_valid=1.
- Full FIFO:
  - If the FIFO is full and no pop occurs in the same cycle, the pushed word is discarded and overflow is set.
  - Counters still advance, so frame geometry is preserved.
  - A push and a pop in the same cycle on a full FIFO succeeds.
- Empty FIFO: word_valid=0. word_data, word_sof and word_eol are don't-care but must not be X after reset.
- overflow_clear:
  - Clears overflow at the next edge.
  - If the clear coincides with a drop, the drop wins and overflow stays 1.
- Upstream cannot be stalled. Sustained throughput is 1 word per 4 pixels, so word_ready must average at least 25 percent.

## Timing
- Reset (asynchronous assert, released synchronously by the system) sets:
  - word_valid=0, word_data=0, word_sof=0, word_eol=0, overflow=0.
  - Counters=0, holding register=0, FIFO empty.
- Reset asserted mid-frame discards the partial word and all FIFO contents. The next accepted pixel becomes row 0, col 0.
- Latency: lane-3 pixel accepted at edge N gives word_valid=1 after edge N when the FIFO was empty (one cycle).
- A pop at edge M removes the head. The next entry, if any, is presented after edge M.
- overflow rises after the edge at which the drop occurred.

## Structure
- A shared package holds:
  - constants DS_ACTIVE_COLS=200, DS_ACTIVE_ROWS=150, DS_WORDS_PER_ROW=50;
  - typedef packed_word_t as a 34-bit struct {eol, sof, data[31:0]}.
- Sub-module ds_word_fifo is a parameterized synchronous FWFT FIFO:
  - inputs push, pop; outputs full, empty;
  - asynchronous active-low reset;
  - pointer width is log2(FIFO_DEPTH)+1.
- Top level holds the counters, holding register, tag logic and overflow flag.

## Test plan
- Single row, word_ready=1, pixels 0x01..0xC8: 50 words. Word 0 = 0x04030201 with sof=1. Word 49 = 0xC8C7C6C5 with eol=1. No other tags.
- Interleaved blanking pixels (data 0x03, blankingregion=1) and valid=0 gaps inside a row: output identical to the gap-free case.
- Full frame of 30000 active pixels, then a second frame: 7500 words per frame. sof only on words 0 and 7500. eol on every 50th word.
- word_ready=0 for 20 consecutive active pixels with FIFO_DEPTH=4: 4 words held and 1 dropped. overflow=1. FIFO contents are words 0..3 in order. overflow_clear then gives overflow=0.
- Full FIFO with push and pop on the same edge: no drop, overflow stays 0, order preserved.
- Reset asserted after pixel col=2 of row 5: all outputs 0 immediately. After release, the next 4 pixels form a word with sof=1.

Source files
------------

// File: rtl/ds_pixel_packer_pkg.sv
// Shared constants and the word record for the downsampler's pixel packer stage.
package ds_pixel_packer_pkg;

  localparam int unsigned DS_ACTIVE_COLS   = 200;
  localparam int unsigned DS_ACTIVE_ROWS   = 150;
  localparam int unsigned DS_WORDS_PER_ROW = DS_ACTIVE_COLS / 4;

  typedef struct packed {
    logic        eol;
    logic        sof;
    logic [31:0] data;
  } packed_word_t;

endpackage

// File: rtl/ds_pixel_packer_if.sv
// Pixel-in / word-out handshake bundle for ds_pixel_packer.
interface ds_pixel_packer_if;

  logic        valid;
  logic [7:0]  data;
  logic        blankingregion;
  logic        word_valid;
  logic [31:0] word_data;
  logic        word_sof;
  logic        word_eol;
  logic        word_ready;

  // Environment side: drives pixels, consumes words.
  modport master (
    output valid,
    output data,
    output blankingregion,
    output word_ready,
    input  word_valid,
    input  word_data,
    input  word_sof,
    input  word_eol
  );

  // Packer side.
  modport slave (
    input  valid,
    input  data,
    input  blankingregion,
    input  word_ready,
    output word_valid,
    output word_data,
    output word_sof,
    output word_eol
  );

endinterface

// File: rtl/ds_word_fifo.sv
// First-word-fall-through FIFO of packed words; storage is reset so the head is never X.
module ds_word_fifo
  import ds_pixel_packer_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  packed_word_t wdata_i,
  input  logic         pop_i,
  output packed_word_t rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned PtrW  = AddrW + 1;

  packed_word_t          mem_q [Depth];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic                  do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);

  // A pop frees the slot in the same edge, so push on full succeeds when popping.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q[AddrW-1:0]];

endmodule

// File: rtl/ds_pixel_packer.sv
// Drops blanking pixels, packs four active pixels per 32-bit word with frame/row tags,
// and queues words toward the frame-buffer writer with a sticky overflow flag.
module ds_pixel_packer
  import ds_pixel_packer_pkg::*;
#(
  parameter int unsigned ActiveCols = DS_ACTIVE_COLS,
  parameter int unsigned ActiveRows = DS_ACTIVE_ROWS,
  parameter int unsigned FifoDepth  = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  ds_pixel_packer_if.slave   bus,
  input  logic               overflow_clear_i,
  output logic               overflow_o
);

  localparam int unsigned ColW = $clog2(ActiveCols);
  localparam int unsigned RowW = $clog2(ActiveRows);
  localparam logic [ColW-1:0] ColLast = ColW'(ActiveCols - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(ActiveRows - 1);

  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;
  logic [23:0]     hold_q, hold_d;
  logic            overflow_q, overflow_d;

  logic            accept;
  logic            push;
  logic            drop;
  logic [1:0]      lane;
  packed_word_t    push_word;
  packed_word_t    head_word;
  logic            fifo_full, fifo_empty;

  assign accept = bus.valid && !bus.blankingregion;
  assign lane   = col_q[1:0];

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    hold_d = hold_q;
    push   = 1'b0;
    if (accept) begin
      if (col_q == ColLast) begin
        col_d = '0;
        row_d = (row_q == RowLast) ? '0 : row_q + RowW'(1);
      end else begin
        col_d = col_q + ColW'(1);
      end
      unique case (lane)
        2'd0: hold_d[7:0]   = bus.data;
        2'd1: hold_d[15:8]  = bus.data;
        2'd2: hold_d[23:16] = bus.data;
        2'd3: push          = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    push_word.data = {bus.data, hold_q};
    push_word.sof  = (row_q == '0) && (col_q == ColW'(3));
    push_word.eol  = (col_q == ColLast);
  end

  // Full implies non-empty, so a ready head is always popped on this edge.
  assign drop = push && fifo_full && !bus.word_ready;

  always_comb begin
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (overflow_clear_i) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q      <= '0;
      row_q      <= '0;
      hold_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      hold_q     <= hold_d;
      overflow_q <= overflow_d;
    end
  end

  ds_word_fifo #(
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .wdata_i (push_word),
    .pop_i   (bus.word_ready),
    .rdata_o (head_word),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.word_valid = !fifo_empty;
  assign bus.word_data  = head_word.data;
  assign bus.word_sof   = head_word.sof;
  assign bus.word_eol   = head_word.eol;
  assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_ds_pixel_packer.sv
// Randomized bench for ds_pixel_packer against a queue-based model of the packed word stream.
module tb_ds_pixel_packer;

  localparam int COLS  = 200;
  localparam int ROWS  = 150;
  localparam int DEPTH = 4;
  localparam int FRAME = COLS * ROWS;

  logic clk = 1'b0;
  logic rst_ni;
  logic ovc;
  logic ovf;

  ds_pixel_packer_if bus ();

  ds_pixel_packer #(
    .ActiveCols (COLS),
    .ActiveRows (ROWS),
    .FifoDepth  (DEPTH)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .bus              (bus),
    .overflow_clear_i (ovc),
    .overflow_o       (ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int vld_err, ov_err, n_acc;
  logic        ov_m;
  logic [7:0]  pix [4];
  logic [33:0] mq[$], exp_q[$], got[$], row_gold[$];
  logic [7:0]  d [24];

  // Model: the n-th accepted pixel since reset completes a word when n%4==3.
  task automatic step(input logic v, input logic [7:0] dat, input logic b, input logic rdy,
                      input logic clr);
    logic [33:0] w;
    logic push_m;
    bus.valid = v; bus.data = dat; bus.blankingregion = b; bus.word_ready = rdy; ovc = clr;
    #1;
    if (bus.word_valid !== (mq.size() > 0)) vld_err++;
    if (ovf !== ov_m) ov_err++;
    if (bus.word_valid === 1'b1 && rdy) got.push_back({bus.word_eol, bus.word_sof, bus.word_data});
    if (mq.size() > 0 && rdy) exp_q.push_back(mq.pop_front());
    push_m = 1'b0;
    w = '0;
    if (v && !b) begin
      pix[n_acc % 4] = dat;
      if (n_acc % 4 == 3) begin
        w = {1'b0, 1'b0, pix[3], pix[2], pix[1], pix[0]};
        w[33] = (n_acc % COLS == COLS - 1);
        w[32] = (n_acc % FRAME == 3);
        push_m = 1'b1;
      end
      n_acc++;
    end
    if (push_m && mq.size() >= DEPTH) ov_m = 1'b1;
    else begin
      if (push_m) mq.push_back(w);
      if (clr) ov_m = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    bus.valid = 1'b0; bus.data = '0; bus.blankingregion = 1'b0; bus.word_ready = 1'b0; ovc = 1'b0;
    rst_ni = 1'b0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    mq.delete(); exp_q.delete(); got.delete();
    n_acc = 0; ov_m = 1'b0; vld_err = 0; ov_err = 0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 1'b0, 1'b1, 1'b0);
  endtask

  function automatic int qdiff();
    int c = 0;
    if (got.size() != exp_q.size()) c++;
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) if (got[i] !== exp_q[i]) c++;
    return c;
  endfunction

  task automatic test_reset();
    apply_reset();
    checks += 5;
    if (bus.word_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b exp 0", bus.word_valid); end
    if (bus.word_data !== 32'h0) begin failures++; $display("FAIL reset_data got %h exp 0", bus.word_data); end
    if (bus.word_sof !== 1'b0) begin failures++; $display("FAIL reset_sof got %b exp 0", bus.word_sof); end
    if (bus.word_eol !== 1'b0) begin failures++; $display("FAIL reset_eol got %b exp 0", bus.word_eol); end
    if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got %b exp 0", ovf); end
  endtask

  task automatic test_single_row();
    int bad = 0;
    apply_reset();
    for (int i = 1; i <= COLS; i++) step(1'b1, 8'(i), 1'b0, 1'b1, 1'b0);
    drain(4);
    for (int k = 0; k < got.size(); k++) begin
      if (got[k][31:0] !== {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)}) bad++;
      if (got[k][32] !== (k == 0) || got[k][33] !== (k == 49)) bad++;
    end
    checks += 5;
    if (got.size() != 50) begin failures++; $display("FAIL row_count got %0d exp 50", got.size()); end
    if (got[0] !== {2'b01, 32'h04030201}) begin failures++; $display("FAIL row_word0 got %h exp 104030201", got[0]); end
    if (got[49] !== {2'b10, 32'hC8C7C6C5}) begin failures++; $display("FAIL row_word49 got %h exp 2c8c7c6c5", got[49]); end
    if (bad != 0) begin failures++; $display("FAIL row_words got %0d bad exp 0", bad); end
    if (qdiff() != 0 || vld_err != 0) begin failures++; $display("FAIL row_model got %0d/%0d exp 0/0", qdiff(), vld_err); end
    row_gold = got;
  endtask

  task automatic test_blanking();
    int bad = 0;
    apply_reset();
    for (int i = 1; i <= COLS; i++) begin
      repeat ($urandom_range(0, 2)) begin
        if ($urandom_range(0, 1) == 1) step(1'b1, 8'h03, 1'b1, 1'b1, 1'b0);
        else step(1'b0, 8'($urandom), 1'b0, 1'b1, 1'b0);
      end
      step(1'b1, 8'(i), 1'b0, 1'b1, 1'b0);
    end
    drain(4);
    for (int k = 0; k < got.size() && k < row_gold.size(); k++) if (got[k] !== row_gold[k]) bad++;
    checks += 2;
    if (got.size() != row_gold.size() || bad != 0) begin
      failures++; $display("FAIL blank_vs_gapfree got %0d words %0d bad exp %0d words 0 bad", got.size(), bad, row_gold.size());
    end
    if (qdiff() != 0 || vld_err != 0) begin failures++; $display("FAIL blank_model got %0d/%0d exp 0/0", qdiff(), vld_err); end
  endtask

  task automatic test_frames();
    int tag_bad = 0;
    apply_reset();
    for (int i = 0; i < 2 * FRAME; i++) step(1'b1, 8'($urandom), 1'b0, 1'b1, 1'b0);
    drain(4);
    for (int k = 0; k < got.size(); k++)
      if (got[k][32] !== (k % 7500 == 0) || got[k][33] !== (k % 50 == 49)) tag_bad++;
    checks += 3;
    if (got.size() != 15000) begin failures++; $display("FAIL frame_count got %0d exp 15000", got.size()); end
    if (tag_bad != 0) begin failures++; $display("FAIL frame_tags got %0d bad exp 0", tag_bad); end
    if (qdiff() != 0 || vld_err != 0 || ov_err != 0) begin
      failures++; $display("FAIL frame_model got %0d/%0d/%0d exp 0/0/0", qdiff(), vld_err, ov_err);
    end
  endtask

  task automatic test_overflow();
    int bad = 0;
    apply_reset();
    for (int i = 0; i < 20; i++) begin d[i] = 8'($urandom); step(1'b1, d[i], 1'b0, 1'b0, 1'b0); end
    checks += 4;
    if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_set got %b exp 1", ovf); end
    if (bus.word_valid !== 1'b1) begin failures++; $display("FAIL ovf_valid got %b exp 1", bus.word_valid); end
    if (bus.word_data !== {d[3], d[2], d[1], d[0]}) begin
      failures++; $display("FAIL ovf_head got %h exp %h", bus.word_data, {d[3], d[2], d[1], d[0]});
    end
    if (bus.word_sof !== 1'b1) begin failures++; $display("FAIL ovf_head_sof got %b exp 1", bus.word_sof); end
    for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b1);
    checks += 1;
    if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_clear_vs_drop got %b exp 1", ovf); end
    drain(6);
    for (int k = 0; k < got.size(); k++)
      if (got[k][31:0] !== {d[4*k+3], d[4*k+2], d[4*k+1], d[4*k]}) bad++;
    checks += 3;
    if (got.size() != 4 || bad != 0) begin failures++; $display("FAIL ovf_held got %0d words %0d bad exp 4 words 0 bad", got.size(), bad); end
    if (qdiff() != 0 || vld_err != 0 || ov_err != 0) begin
      failures++; $display("FAIL ovf_model got %0d/%0d/%0d exp 0/0/0", qdiff(), vld_err, ov_err);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    if (ovf !== 1'b0) begin failures++; $display("FAIL ovf_clear got %b exp 0", ovf); end
  endtask

  task automatic test_push_pop_full();
    apply_reset();
    for (int i = 0; i < 19; i++) begin d[i] = 8'($urandom); step(1'b1, d[i], 1'b0, 1'b0, 1'b0); end
    d[19] = 8'($urandom);
    step(1'b1, d[19], 1'b0, 1'b1, 1'b0);
    checks += 1;
    if (ovf !== 1'b0) begin failures++; $display("FAIL pp_no_drop got %b exp 0", ovf); end
    drain(6);
    checks += 2;
    if (got.size() != 5 || got[4][31:0] !== {d[19], d[18], d[17], d[16]}) begin
      failures++; $display("FAIL pp_order got %0d words last %h exp 5 words last %h", got.size(), got[4][31:0], {d[19], d[18], d[17], d[16]});
    end
    if (qdiff() != 0 || vld_err != 0 || ov_err != 0) begin
      failures++; $display("FAIL pp_model got %0d/%0d/%0d exp 0/0/0", qdiff(), vld_err, ov_err);
    end
  endtask

  task automatic test_midframe_reset();
    apply_reset();
    for (int i = 0; i < 5 * COLS - 12; i++) step(1'b1, 8'($urandom), 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    checks += 1;
    if (bus.word_valid !== 1'b1) begin failures++; $display("FAIL mid_pre_valid got %b exp 1", bus.word_valid); end
    #2 rst_ni = 1'b0;
    #1;
    checks += 1;
    if ({bus.word_valid, bus.word_data, bus.word_sof, bus.word_eol, ovf} !== 36'h0) begin
      failures++; $display("FAIL mid_reset_outputs got %h exp 0", {bus.word_valid, bus.word_data, bus.word_sof, bus.word_eol, ovf});
    end
    apply_reset();
    for (int i = 0; i < 4; i++) begin d[i] = 8'($urandom); step(1'b1, d[i], 1'b0, 1'b1, 1'b0); end
    drain(3);
    checks += 1;
    if (got.size() != 1 || got[0] !== {2'b01, d[3], d[2], d[1], d[0]}) begin
      failures++; $display("FAIL mid_first_word got %0d words %h exp 1 word %h", got.size(), got[0], {2'b01, d[3], d[2], d[1], d[0]});
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 4000; i++)
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 4) == 0),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 49) == 0));
    drain(6);
    checks += 3;
    if (qdiff() != 0) begin failures++; $display("FAIL rand_words got %0d diffs exp 0", qdiff()); end
    if (vld_err != 0) begin failures++; $display("FAIL rand_valid got %0d errs exp 0", vld_err); end
    if (ov_err != 0) begin failures++; $display("FAIL rand_overflow got %0d errs exp 0", ov_err); end
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_blanking();
    test_frames();
    test_overflow();
    test_push_pop_full();
    test_midframe_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
